// File: rtl/parallel_serializer_pkg.sv
// -----------------------------------------------------------------------------
// parallel_serializer_pkg
// Shared definitions for the parallel-to-serial converter:
//   - state_t      : FSM state encoding (PARITY state exists only when the
//                    PARALLEL_SERIALIZER_PARITY_EN macro is defined)
//   - WIDTH_MIN/MAX: legal range of the parallel word width
//   - width_in_range(): helper used for an elaboration-time width check
// -----------------------------------------------------------------------------
package parallel_serializer_pkg;

`ifdef PARALLEL_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_in_range(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/parallel_serializer_bit_counter.sv
// -----------------------------------------------------------------------------
// serializer_bit_counter
// Bit-position counter for the serializer. Counts 0..WIDTH-1 and saturates at
// WIDTH-1 so the index can never wrap inside a frame.
// Ports:
//   clk      in   clock (rising edge)
//   rst      in   asynchronous active-high reset, clears the count
//   clear    in   synchronous clear to 0 (has priority over enable)
//   enable   in   advance the count by one
//   count    out  current bit index, $clog2(WIDTH) bits
//   terminal out  count == WIDTH-1
// -----------------------------------------------------------------------------
module serializer_bit_counter
    import parallel_serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     terminal
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    assign terminal = (count == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parallel_serializer.sv
// -----------------------------------------------------------------------------
// parallel_serializer
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock, MSB or LSB first. All outputs are registered.
// Optional feature: define PARALLEL_SERIALIZER_PARITY_EN to append one even
// parity bit after the data bits (frame becomes WIDTH+1 cycles).
// Ports:
//   input_clock          in   clock, all state updates on the rising edge
//   input_reset          in   asynchronous active-high reset
//   input_data           in   parallel word, sampled only on accept
//   input_valid          in   producer offers input_data
//   output_ready         out  a word can be accepted at the next rising edge
//   output_serial        out  serial bit stream
//   output_load_shift    out  high during the first bit cycle of a frame
//   output_bit_index     out  index of the data bit currently on output_serial
//   output_busy          out  frame in progress
//   output_parity_phase  out  parity bit currently on output_serial
// -----------------------------------------------------------------------------
module parallel_serializer
    import parallel_serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                     input_clock,
    input  logic                     input_reset,
    input  logic [WIDTH-1:0]         input_data,
    input  logic                     input_valid,
    output logic                     output_ready,
    output logic                     output_serial,
    output logic                     output_load_shift,
    output logic [$clog2(WIDTH)-1:0] output_bit_index,
    output logic                     output_busy,
    output logic                     output_parity_phase
);

    localparam int IDX_W = $clog2(WIDTH);

    generate
        if (!width_in_range(WIDTH)) begin : g_bad_width
            $error("parallel_serializer: WIDTH out of range 2..32");
        end
    endgenerate

    // The shifter always sends its top bit first; for LSB-first operation the
    // word is bit-reversed on the way in so a single shift direction serves
    // both orders.
    logic [WIDTH-1:0] ordered;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST != 0) begin : g_msb
                assign ordered[gi] = input_data[gi];
            end else begin : g_lsb
                assign ordered[gi] = input_data[WIDTH-1-gi];
            end
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic             ready_reg;
    logic             serial_reg;
    logic             load_reg;
    logic             busy_reg;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_last;
    logic [IDX_W-1:0] cnt_value;

`ifdef PARALLEL_SERIALIZER_PARITY_EN
    logic             parity_bit;
    logic             parity_phase_reg;
    assign output_parity_phase = parity_phase_reg;
`else
    assign output_parity_phase = 1'b0;
`endif

    assign accept = input_valid & ready_reg;

    // Counter sits at 0 outside a frame; it is cleared when a new word is
    // taken and when the frame ends. With parity it holds WIDTH-1 through
    // the parity cycle.
    always_comb begin
        cnt_enable = (state == ST_SHIFT) && !cnt_last && !accept;
`ifdef PARALLEL_SERIALIZER_PARITY_EN
        cnt_clear  = accept || (state != ST_SHIFT);
`else
        cnt_clear  = accept || (state != ST_SHIFT) || cnt_last;
`endif
    end

    serializer_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (input_clock),
        .rst      (input_reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (cnt_value),
        .terminal (cnt_last)
    );

    always_ff @(posedge input_clock or posedge input_reset) begin
        if (input_reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            ready_reg  <= 1'b1;
            serial_reg <= 1'b0;
            load_reg   <= 1'b0;
            busy_reg   <= 1'b0;
`ifdef PARALLEL_SERIALIZER_PARITY_EN
            parity_bit       <= 1'b0;
            parity_phase_reg <= 1'b0;
`endif
        end else if (accept) begin
            // Taken from IDLE or from the final cycle of the previous frame.
            state      <= ST_SHIFT;
            serial_reg <= ordered[WIDTH-1];
            shift_reg  <= {ordered[WIDTH-2:0], 1'b0};
            load_reg   <= 1'b1;
            busy_reg   <= 1'b1;
            ready_reg  <= 1'b0;
`ifdef PARALLEL_SERIALIZER_PARITY_EN
            parity_bit       <= ^input_data;
            parity_phase_reg <= 1'b0;
`endif
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!cnt_last) begin
                        serial_reg <= shift_reg[WIDTH-1];
                        shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
                        load_reg   <= 1'b0;
`ifdef PARALLEL_SERIALIZER_PARITY_EN
                        ready_reg  <= 1'b0;
`else
                        // The upcoming cycle is the last data bit.
                        ready_reg  <= (cnt_value == IDX_W'(WIDTH - 2));
`endif
                    end else begin
`ifdef PARALLEL_SERIALIZER_PARITY_EN
                        state            <= ST_PARITY;
                        serial_reg       <= parity_bit;
                        parity_phase_reg <= 1'b1;
                        load_reg         <= 1'b0;
                        ready_reg        <= 1'b1;
`else
                        state      <= ST_IDLE;
                        serial_reg <= 1'b0;
                        load_reg   <= 1'b0;
                        busy_reg   <= 1'b0;
                        ready_reg  <= 1'b1;
`endif
                    end
                end
`ifdef PARALLEL_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    state            <= ST_IDLE;
                    serial_reg       <= 1'b0;
                    load_reg         <= 1'b0;
                    busy_reg         <= 1'b0;
                    ready_reg        <= 1'b1;
                    parity_phase_reg <= 1'b0;
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    serial_reg <= 1'b0;
                    load_reg   <= 1'b0;
                    busy_reg   <= 1'b0;
                    ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign output_ready      = ready_reg;
    assign output_serial     = serial_reg;
    assign output_load_shift = load_reg;
    assign output_busy       = busy_reg;
    assign output_bit_index  = cnt_value;

endmodule

// File: tb/tb_parallel_serializer.sv
// -----------------------------------------------------------------------------
// tb_parallel_serializer
// Two instances share one stimulus stream: u_msb (MSB_FIRST=1) and
// u_lsb (MSB_FIRST=0). A frame-position model predicts every output each
// cycle; directed sequences additionally pin literal bit patterns.
// Honours PARALLEL_SERIALIZER_PARITY_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_parallel_serializer;

    localparam int W = 4;
`ifdef PARALLEL_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] data  = '0;

    logic         a_ready, a_serial, a_load, a_busy, a_par;
    logic [1:0]   a_idx;
    logic         b_ready, b_serial, b_load, b_busy, b_par;
    logic [1:0]   b_idx;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    parallel_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .input_clock         (clk),
        .input_reset         (rst),
        .input_data          (data),
        .input_valid         (valid),
        .output_ready        (a_ready),
        .output_serial       (a_serial),
        .output_load_shift   (a_load),
        .output_bit_index    (a_idx),
        .output_busy         (a_busy),
        .output_parity_phase (a_par)
    );

    parallel_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .input_clock         (clk),
        .input_reset         (rst),
        .input_data          (data),
        .input_valid         (valid),
        .output_ready        (b_ready),
        .output_serial       (b_serial),
        .output_load_shift   (b_load),
        .output_bit_index    (b_idx),
        .output_busy         (b_busy),
        .output_parity_phase (b_par)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model: frame position ----------------
    bit         act_m  = 1'b0;
    logic [W-1:0] word_m = '0;
    int         pos_m  = 0;

    function automatic bit m_ready();
        return !act_m || (pos_m == FRAME - 1);
    endfunction

    function automatic logic m_serial(input bit msb);
        if (!act_m)      return 1'b0;
        if (pos_m < W)   return msb ? word_m[W-1-pos_m] : word_m[pos_m];
        return ^word_m;
    endfunction

    function automatic logic [31:0] m_index();
        if (!act_m) return 0;
        return (pos_m < W) ? pos_m : W - 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act_m <= 1'b0;
            pos_m <= 0;
        end else if (valid && m_ready()) begin
            act_m  <= 1'b1;
            word_m <= data;
            pos_m  <= 0;
            $display("accept word=%h t=%0t", data, $time);
        end else if (act_m) begin
            if (pos_m == FRAME - 1) begin
                act_m <= 1'b0;
                pos_m <= 0;
            end else begin
                pos_m <= pos_m + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("a_ready",  a_ready,  m_ready());
            check("a_serial", a_serial, m_serial(1'b1));
            check("a_load",   a_load,   act_m && pos_m == 0);
            check("a_index",  a_idx,    m_index());
            check("a_busy",   a_busy,   act_m);
            check("a_parity", a_par,    act_m && pos_m == W);
            check("b_ready",  b_ready,  m_ready());
            check("b_serial", b_serial, m_serial(1'b0));
            check("b_load",   b_load,   act_m && pos_m == 0);
            check("b_index",  b_idx,    m_index());
            check("b_busy",   b_busy,   act_m);
            check("b_parity", b_par,    act_m && pos_m == W);
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [W-1:0] sa, sb, lseq, bseq;
    logic [7:0]   iseq, s8a, s8b;
    bit           busy_all;

    initial begin
        repeat (2) @(negedge clk);
        // Reset values
        check("rst_ready",  a_ready, 1);
        check("rst_serial", a_serial, 0);
        check("rst_busy",   a_busy, 0);
        check("rst_load",   a_load, 0);
        check("rst_index",  a_idx, 0);
        check("rst_parity", a_par, 0);
        rst = 1'b0;
        check_en = 1'b1;

        // Single word 1011
        @(negedge clk); valid = 1'b1; data = 4'b1011;
        @(negedge clk); valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            sa   = {sa[W-2:0], a_serial};
            iseq = {iseq[5:0], a_idx};
            lseq = {lseq[W-2:0], a_load};
            bseq = {bseq[W-2:0], a_busy};
            @(negedge clk);
        end
        repeat (PAR) @(negedge clk);
        check("single_serial", sa, 4'b1011);
        check("single_index",  iseq, 8'h1B);
        check("single_load",   lseq, 4'b1000);
        check("single_busy",   bseq, 4'b1111);
        check("single_idle",   a_busy, 0);

        // LSB-first 0001 on u_lsb, MSB-first on u_msb
        valid = 1'b1; data = 4'b0001;
        @(negedge clk); valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            sa = {sa[W-2:0], a_serial};
            sb = {sb[W-2:0], b_serial};
            @(negedge clk);
        end
        repeat (PAR) @(negedge clk);
        check("lsb_serial", sb, 4'b1000);
        check("msb_serial", sa, 4'b0001);

        // Back-to-back A then 5 with valid held
        valid = 1'b1; data = 4'hA;
        @(negedge clk); data = 4'h5;
        busy_all = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (!a_par) begin
                s8a = {s8a[6:0], a_serial};
                s8b = {s8b[6:0], b_serial};
            end
            busy_all = busy_all & (a_busy === 1'b1);
            if (i == FRAME) valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_msb",  s8a, 8'b1010_0101);
        check("b2b_lsb",  s8b, 8'b0101_1010);
        check("b2b_busy", busy_all, 1);

        // Mid-frame reset, then F sent cleanly
        repeat (2) @(negedge clk);
        valid = 1'b1; data = 4'b0110;
        @(negedge clk); valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_index", a_idx, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready",  a_ready, 1);
        check("mid_rst_busy",   a_busy, 0);
        check("mid_rst_serial", a_serial, 0);
        check("mid_rst_index",  a_idx, 0);
        check("mid_rst_load",   a_load, 0);
        @(negedge clk); rst = 1'b0; valid = 1'b1; data = 4'hF;
        @(negedge clk); valid = 1'b0;
        check("post_rst_load", a_load, 1);
        for (int i = 0; i < W; i++) begin
            sa = {sa[W-2:0], a_serial};
            @(negedge clk);
        end
        repeat (PAR) @(negedge clk);
        check("post_rst_serial", sa, 4'b1111);

`ifdef PARALLEL_SERIALIZER_PARITY_EN
        begin
            logic [4:0] s5, r5, p5;
            valid = 1'b1; data = 4'b0111;
            @(negedge clk); valid = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                s5 = {s5[3:0], a_serial};
                r5 = {r5[3:0], a_ready};
                p5 = {p5[3:0], a_par};
                if (i == FRAME - 1) check("par_index", a_idx, 3);
                @(negedge clk);
            end
            check("par_serial", s5, 5'b01111);
            check("par_ready",  r5, 5'b00001);
            check("par_phase",  p5, 5'b00001);
        end
`endif

        // Randomized traffic with occasional short reset pulses
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            data  = W'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk); valid = 1'b0;
        repeat (FRAME + 2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
